ulpb_node_rx: RTL and testbench



---
 rtl/ulpb_pkg.sv | 39 +++
 rtl/ulpb_rx_fifo.sv | 76 +++++++
 rtl/ulpb_node_rx.sv | 250 +++++++++++++++++++++++++
 tb/tb_ulpb_node_rx.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ulpb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ulpb_pkg
// Description : Shared definitions for the ULPB node receive path. Holds the
//               receive FSM state encodings, the broadcast address, the
//               payload FIFO entry width ({sof, byte}), and a ceiling-log2
//               helper used for counter and pointer sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package ulpb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DATA  = 3'd3,
        ST_DROP  = 3'd4
    } ulpb_state_e;

    // All-ones address; only the low ADDR_WIDTH bits are compared
    localparam logic [7:0] c_bcast_addr = 8'hFF;

    // FIFO entry: {sof, payload byte}
    localparam int c_fifo_width = 9;

    // Ceiling log2; returns 0 for values of 0 or 1
    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ulpb_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ulpb_rx_fifo
// Description : Synchronous FIFO with registered storage and count. Push and
//               pop in the same cycle are both honoured, including when
//               full. There is no empty bypass: a byte pushed into an empty
//               FIFO is visible on o_dout the following cycle.
// Ports       : clk, rst (async, active-high)
//               i_push/i_din  - write request and data
//               i_pop         - read request (ignored when empty)
//               o_dout        - head entry
//               o_full/o_empty/o_count - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module ulpb_rx_fifo
    import ulpb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_push,
    input  logic [WIDTH-1:0]     i_din,
    input  logic                 i_pop,
    output logic [WIDTH-1:0]     o_dout,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [log2(DEPTH):0] o_count
);

    localparam int                  c_ptr_w = log2(DEPTH);
    localparam logic [c_ptr_w:0]    c_depth = (c_ptr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_rd;
    logic               w_wr;

    assign w_rd = i_pop && (r_count != '0);
    // A simultaneous pop frees the slot, so a full FIFO still accepts
    assign w_wr = i_push && ((r_count != c_depth) || w_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == c_depth);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/ulpb_node_rx.sv
`default_nettype none
// ============================================================================
// Module      : ulpb_node_rx
// Description : Per-node ULPB receive front end. Oversamples the upstream
//               bus clock and data with CLK, tracks frames, filters on the
//               destination address and queues accepted payload bytes in a
//               small FIFO. Reports done/error at end of an accepted frame.
//               Ring data is forwarded combinationally on BUS_DOUT.
// Ports       : CLK, RESET (async, active-high)
//               BUS_CLK_IN, BUS_DIN - asynchronous bus inputs
//               BUS_DOUT            - ring forward of BUS_DIN
//               RX_DATA, RX_SOF, RX_VALID, RX_READY - payload stream
//               RX_DONE, RX_ERR     - end-of-frame status (ERR qualified
//                                     by DONE)
// Config      : define ULPB_RX_BCAST_EN to also accept the all-ones address
// Revision    : 1.0 - initial release
// ============================================================================
module ulpb_node_rx
    import ulpb_pkg::*;
#(
    parameter logic [7:0] NODE_ADDR    = 8'h01,
    parameter int         ADDR_WIDTH   = 8,
    parameter int         IDLE_TIMEOUT = 16,
    parameter int         FIFO_DEPTH   = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BUS_CLK_IN,
    input  logic       BUS_DIN,
    output logic       BUS_DOUT,
    output logic [7:0] RX_DATA,
    output logic       RX_SOF,
    output logic       RX_VALID,
    input  logic       RX_READY,
    output logic       RX_DONE,
    output logic       RX_ERR
);

    localparam int                  c_tmo_w    = log2(IDLE_TIMEOUT) + 1;
    localparam logic [c_tmo_w-1:0]  c_tmo_last = c_tmo_w'(IDLE_TIMEOUT - 1);
    localparam logic [3:0]          c_addr_last = 4'(ADDR_WIDTH - 1);
    localparam int                  c_cnt_w    = log2(FIFO_DEPTH) + 1;

    // ------------------------------------------------------------------
    // Synchronizers and edge detection
    // ------------------------------------------------------------------
    logic r_bclk_s1, r_bclk_s2, r_bclk_h;
    logic r_din_s1,  r_din_s2,  r_din_h;
    logic w_bclk_rise, w_bclk_fall, w_din_fall;

    // Reset to 0 so that a low pin after reset can never look like a fall
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_bclk_s1 <= 1'b0;
            r_bclk_s2 <= 1'b0;
            r_bclk_h  <= 1'b0;
            r_din_s1  <= 1'b0;
            r_din_s2  <= 1'b0;
            r_din_h   <= 1'b0;
        end else begin
            r_bclk_s1 <= BUS_CLK_IN;
            r_bclk_s2 <= r_bclk_s1;
            r_bclk_h  <= r_bclk_s2;
            r_din_s1  <= BUS_DIN;
            r_din_s2  <= r_din_s1;
            r_din_h   <= r_din_s2;
        end
    end

    assign w_bclk_rise = r_bclk_s2 & ~r_bclk_h;
    assign w_bclk_fall = ~r_bclk_s2 & r_bclk_h;
    assign w_din_fall  = ~r_din_s2 & r_din_h;

    // ------------------------------------------------------------------
    // Frame tracking state
    // ------------------------------------------------------------------
    ulpb_state_e        r_state;
    ulpb_state_e        w_state_nxt;
    logic [c_tmo_w-1:0] r_tmo;
    logic [3:0]         r_bitcnt;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_nxt;
    logic               w_tmo_hit;
    logic               w_addr_last;
    logic               w_byte_done;
    logic               w_start;
    logic               w_node_match;
    logic               w_bcast_match;
    logic               w_addr_match;

    assign w_shift_nxt   = {r_shift[6:0], r_din_s2};
    assign w_tmo_hit     = (r_state != ST_IDLE) && (r_tmo == c_tmo_last);
    assign w_addr_last   = (r_state == ST_ADDR) && w_bclk_rise && (r_bitcnt == c_addr_last);
    assign w_byte_done   = (r_state == ST_DATA) && w_bclk_rise && (r_bitcnt == 4'd7);
    assign w_start       = (r_state == ST_IDLE) && (w_state_nxt == ST_START);
    assign w_node_match  = (w_shift_nxt[ADDR_WIDTH-1:0] == NODE_ADDR[ADDR_WIDTH-1:0]);
    assign w_bcast_match = (w_shift_nxt[ADDR_WIDTH-1:0] == c_bcast_addr[ADDR_WIDTH-1:0]);

`ifdef ULPB_RX_BCAST_EN
    assign w_addr_match = w_node_match | w_bcast_match;
`else
    assign w_addr_match = w_node_match;
    logic w_unused_bcast;
    assign w_unused_bcast = w_bcast_match;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_din_fall && r_bclk_s2) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_tmo_hit) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_bclk_rise) begin
                    // Arbitration bit is consumed without being stored
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (w_tmo_hit) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_addr_last) begin
                    w_state_nxt = w_addr_match ? ST_DATA : ST_DROP;
                end
            end
            ST_DATA, ST_DROP: begin
                if (w_tmo_hit) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Counters, shifter and push/status generation
    // ------------------------------------------------------------------
    logic               r_push;
    logic [8:0]         r_push_data;
    logic               r_first;
    logic               r_ovf;
    logic               r_done;
    logic               r_err;
    logic [8:0]         w_fifo_dout;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [c_cnt_w-1:0] w_fifo_count;
    logic               w_pop;
    logic               w_ovf_set;

    assign w_pop     = RX_READY && !w_fifo_empty;
    assign w_ovf_set = r_push && w_fifo_full && !w_pop;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_tmo       <= '0;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_first     <= 1'b0;
            r_ovf       <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // Any bus-clock edge proves the frame is still alive
            if ((r_state == ST_IDLE) || w_tmo_hit || w_bclk_rise || w_bclk_fall) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end

            case (r_state)
                ST_ADDR: begin
                    if (w_bclk_rise) begin
                        r_bitcnt <= w_addr_last ? 4'd0 : r_bitcnt + 4'd1;
                    end
                end
                ST_DATA: begin
                    if (w_bclk_rise) begin
                        r_bitcnt <= (r_bitcnt == 4'd7) ? 4'd0 : r_bitcnt + 4'd1;
                    end
                end
                default: r_bitcnt <= 4'd0;
            endcase

            if (((r_state == ST_ADDR) || (r_state == ST_DATA)) && w_bclk_rise) begin
                r_shift <= w_shift_nxt;
            end

            r_push      <= w_byte_done;
            r_push_data <= {r_first, w_shift_nxt};

            if (w_start) begin
                r_first <= 1'b1;
            end else if (w_byte_done) begin
                r_first <= 1'b0;
            end

            if (w_start) begin
                r_ovf <= 1'b0;
            end else if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end

            r_done <= w_tmo_hit && (r_state == ST_DATA);
            r_err  <= w_tmo_hit && (r_state == ST_DATA)
                      && ((r_bitcnt != 4'd0) || r_ovf || w_ovf_set);
        end
    end

    // ------------------------------------------------------------------
    // Payload FIFO
    // ------------------------------------------------------------------
    ulpb_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_fifo_width)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RESET),
        .i_push  (r_push),
        .i_din   (r_push_data),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign BUS_DOUT = BUS_DIN;
    assign RX_DATA  = w_fifo_dout[7:0];
    assign RX_SOF   = w_fifo_dout[8];
    assign RX_VALID = (w_fifo_count != '0);
    assign RX_DONE  = r_done;
    assign RX_ERR   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ulpb_node_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ulpb_node_rx
// Description : Self-checking bench for ulpb_node_rx. Expected payload
//               entries and end-of-frame status are queued as frames are
//               driven and compared when the DUT hands them over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ulpb_node_rx;

    localparam logic [7:0] c_node  = 8'h01;
    localparam int         c_tmo   = 16;
    localparam int         c_depth = 4;
    localparam int         c_half  = 4;
`ifdef ULPB_RX_BCAST_EN
    localparam bit         c_bcast = 1'b1;
`else
    localparam bit         c_bcast = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET;
    logic       BUS_CLK_IN;
    logic       BUS_DIN;
    logic       BUS_DOUT;
    logic [7:0] RX_DATA;
    logic       RX_SOF;
    logic       RX_VALID;
    logic       RX_READY;
    logic       RX_DONE;
    logic       RX_ERR;

    int         n_checks      = 0;
    int         n_errors      = 0;
    int         cyc           = 0;
    int         last_rise_cyc = 0;
    int         pop_cnt       = 0;
    bit         rdy_model     = 1'b0;
    logic [8:0] sb_q [$];
    logic       dq [$];
    logic [7:0] tx_q [$];

    ulpb_node_rx #(
        .NODE_ADDR    (c_node),
        .ADDR_WIDTH   (8),
        .IDLE_TIMEOUT (c_tmo),
        .FIFO_DEPTH   (c_depth)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .BUS_CLK_IN (BUS_CLK_IN),
        .BUS_DIN    (BUS_DIN),
        .BUS_DOUT   (BUS_DOUT),
        .RX_DATA    (RX_DATA),
        .RX_SOF     (RX_SOF),
        .RX_VALID   (RX_VALID),
        .RX_READY   (RX_READY),
        .RX_DONE    (RX_DONE),
        .RX_ERR     (RX_ERR)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Output monitor: sampled on the falling edge, away from the active edge
    always @(negedge CLK) begin
        logic [8:0] e;
        int         lat;
        if (!RESET) begin
            if (RX_VALID && RX_READY) begin
                pop_cnt++;
                chk("sb_avail", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("rx_byte", 32'({RX_SOF, RX_DATA}), 32'(e));
                end
            end
            if (RX_DONE) begin
                chk("done_exp", 32'(dq.size() != 0), 32'd1);
                if (dq.size() != 0) begin
                    chk("rx_err", 32'(RX_ERR), 32'(dq.pop_front()));
                end
                lat = cyc - last_rise_cyc;
                chk("done_lat", 32'((lat >= c_tmo) && (lat <= c_tmo + 5)), 32'd1);
            end else if (RX_ERR) begin
                chk("err_no_done", 32'(RX_ERR), 32'd0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // One bus bit; optionally pulse RX_READY for the single cycle in which
    // the byte completed by this bit is pushed into the FIFO
    task automatic send_bit(input logic b, input bit pulse);
        BUS_CLK_IN = 1'b0;
        BUS_DIN    = b;
        tick(c_half);
        BUS_CLK_IN    = 1'b1;
        last_rise_cyc = cyc;
        for (int i = 1; i <= c_half; i++) begin
            tick(1);
            if (pulse && (i == 3)) RX_READY = 1'b1;
            if (pulse && (i == 4)) RX_READY = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            send_bit(b[7-i], 1'b0);
        end
    endtask

    task automatic frame_start(input logic [7:0] addr);
        BUS_CLK_IN = 1'b1;
        BUS_DIN    = 1'b1;
        tick(c_half);
        BUS_DIN = 1'b0;
        tick(c_half);
        send_bit(1'b1, 1'b0);
        send_byte(addr, 8);
    endtask

    task automatic tx_byte(input logic [7:0] b, input bit first, input bit match,
                           input bit pulse, inout bit ovf);
        send_byte(b, 7);
        if (match) begin
            if (!rdy_model && !pulse && (sb_q.size() >= c_depth)) ovf = 1'b1;
            else sb_q.push_back({first, b});
        end
        send_bit(b[0], pulse);
    endtask

    task automatic send_frame(input logic [7:0] addr, input int extra, input bit pulse_last);
        bit match;
        bit ovf;
        bit pl;
        match = (addr == c_node) || (c_bcast && (addr == 8'hFF));
        ovf   = 1'b0;
        frame_start(addr);
        for (int i = 0; i < tx_q.size(); i++) begin
            pl = pulse_last && (i == tx_q.size() - 1);
            tx_byte(tx_q[i], i == 0, match, pl, ovf);
        end
        if (extra > 0) send_byte(8'hA0, extra);
        if (match) dq.push_back(ovf || (extra != 0));
        tick(c_tmo + 10);
        chk("done_seen", 32'(dq.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ovf;
        RESET      = 1'b1;
        BUS_CLK_IN = 1'b1;
        BUS_DIN    = 1'b1;
        RX_READY   = 1'b0;
        tick(3);
        chk("rst_valid", 32'(RX_VALID), 32'd0);
        chk("rst_data",  32'(RX_DATA),  32'd0);
        chk("rst_sof",   32'(RX_SOF),   32'd0);
        chk("rst_done",  32'(RX_DONE),  32'd0);
        chk("rst_err",   32'(RX_ERR),   32'd0);
        chk("dout_hi",   32'(BUS_DOUT), 32'd1);
        BUS_DIN = 1'b0;
        #1;
        chk("dout_lo",   32'(BUS_DOUT), 32'd0);
        BUS_DIN = 1'b1;
        RESET   = 1'b0;
        tick(4);

        // Basic accepted frame, consumer always ready
        RX_READY = 1'b1; rdy_model = 1'b1; pop_cnt = 0;
        tx_q = '{8'hA5, 8'h3C};
        send_frame(c_node, 0, 1'b0);
        chk("f1_pops", 32'(pop_cnt), 32'd2);

        // Other node's address: dropped silently
        pop_cnt = 0;
        tx_q = '{8'h11, 8'h22};
        send_frame(8'h02, 0, 1'b0);
        chk("f2_pops", 32'(pop_cnt), 32'd0);

        // Broadcast address: accepted only with the broadcast build option
        pop_cnt = 0;
        tx_q = '{8'h77};
        send_frame(8'hFF, 0, 1'b0);
        chk("bc_pops", 32'(pop_cnt), c_bcast ? 32'd1 : 32'd0);

        // Overflow: consumer stalled, six bytes into a four-entry FIFO
        RX_READY = 1'b0; rdy_model = 1'b0;
        tx_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        send_frame(c_node, 0, 1'b0);
        chk("ovf_valid", 32'(RX_VALID), 32'd1);
        chk("ovf_head",  32'({RX_SOF, RX_DATA}), 32'(sb_q[0]));
        tick(5);
        chk("ovf_hold",  32'({RX_SOF, RX_DATA}), 32'(sb_q[0]));
        pop_cnt = 0;
        RX_READY = 1'b1; rdy_model = 1'b1;
        tick(12);
        chk("drain_cnt", 32'(pop_cnt), 32'd4);
        chk("drain_sb",  32'(sb_q.size()), 32'd0);
        chk("drain_vld", 32'(RX_VALID), 32'd0);

        // Clean frame after overflow: error flag must have cleared
        tx_q = '{8'hC3};
        send_frame(c_node, 0, 1'b0);

        // Partial trailing byte: one byte plus four bits
        tx_q = '{8'h5A};
        send_frame(c_node, 4, 1'b0);

        // Full FIFO with a pop coinciding with the next push
        RX_READY = 1'b0; rdy_model = 1'b0;
        tx_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(c_node, 0, 1'b0);
        tx_q = '{8'h99};
        send_frame(c_node, 0, 1'b1);
        pop_cnt = 0;
        RX_READY = 1'b1; rdy_model = 1'b1;
        tick(12);
        chk("full_pop_cnt", 32'(pop_cnt), 32'd4);
        chk("full_pop_sb",  32'(sb_q.size()), 32'd0);

        // Reset in the middle of DATA with two bytes queued
        RX_READY = 1'b0; rdy_model = 1'b0;
        ovf = 1'b0;
        frame_start(c_node);
        tx_byte(8'h81, 1'b1, 1'b1, 1'b0, ovf);
        tx_byte(8'h42, 1'b0, 1'b1, 1'b0, ovf);
        send_byte(8'hE0, 3);
        chk("pre_rst_valid", 32'(RX_VALID), 32'd1);
        RESET = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(RX_VALID), 32'd0);
        chk("mid_rst_data",  32'(RX_DATA),  32'd0);
        chk("mid_rst_sof",   32'(RX_SOF),   32'd0);
        sb_q.delete();
        dq.delete();
        BUS_DIN = 1'b1;
        tick(3);
        RESET = 1'b0;
        tick(3);

        // Fresh frame after reset
        pop_cnt = 0;
        RX_READY = 1'b1; rdy_model = 1'b1;
        tx_q = '{8'hE7};
        send_frame(c_node, 0, 1'b0);
        chk("post_rst_pops", 32'(pop_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
